// File: rtl/shift_arb_ctrl.sv
// Two-requester arbiter in front of a shared combinational shifter; round-robin by default.
// Define SHIFT_ARB_FIXED_PRIO_EN to make requester 0 always win ties, which drops the last-grant register.
module shift_arb_ctrl #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic [W-1:0] sh_a,
  output logic [W-1:0] sh_b,
  input  logic [W-1:0] sh_s,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [W-1:0] resp_s,
  input  logic         resp_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] lat_a, lat_b;
  logic         lat_id;
  logic         grant0, grant1, accept;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  logic         last_grant;
`endif

  // Grants are only offered in IDLE and are masked while reset is asserted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  assign accept = grant0 | grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_a   <= '0;
      lat_b   <= '0;
      lat_id  <= 1'b0;
      resp_s  <= '0;
      resp_id <= 1'b0;
    end else begin
      if (accept) begin
        lat_a  <= grant1 ? req1_a : req0_a;
        lat_b  <= grant1 ? req1_b : req0_b;
        lat_id <= grant1;
      end
      if (state == ISSUE) begin
        resp_s  <= sh_s;
        resp_id <= lat_id;
      end
    end
  end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  // Reset value 1 means "requester 1 went last", so requester 0 takes the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = (state == RESP);
  assign sh_a       = (state == ISSUE) ? lat_a : '0;
  assign sh_b       = (state == ISSUE) ? lat_b : '0;

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Table-driven bench for shift_arb_ctrl with a logical right-shifter model on sh_a/sh_b.
// Handles both the round-robin build and the SHIFT_ARB_FIXED_PRIO_EN build.
module tb_shift_arb_ctrl;

  localparam int W = 6;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic         clk, rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] sh_a, sh_b, sh_s, resp_s;
  logic         resp_valid, resp_id, resp_ready;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic v0; logic [W-1:0] a0, b0;
    logic v1; logic [W-1:0] a1, b1;
    logic rr;
    logic e_r0, e_r1, e_rv, e_id;
    logic [W-1:0] e_s, e_sha, e_shb;
  } vec_t;

  vec_t vecs[$];

  shift_arb_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .sh_a(sh_a), .sh_b(sh_b), .sh_s(sh_s),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_s(resp_s), .resp_ready(resp_ready)
  );

  // External shared shifter: logical right shift, zero-filled, W bits
  assign sh_s = sh_a >> sh_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(logic v0, logic [W-1:0] a0, logic [W-1:0] b0,
                               logic v1, logic [W-1:0] a1, logic [W-1:0] b1, logic rr,
                               logic r0, logic r1, logic rv, logic id,
                               logic [W-1:0] s, logic [W-1:0] sha, logic [W-1:0] shb);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.e_r0 = r0; v.e_r1 = r1; v.e_rv = rv; v.e_id = id;
    v.e_s = s; v.e_sha = sha; v.e_shb = shb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    resp_ready = v.rr;
  endtask

  task automatic checkOutput(vec_t v, string tag);
    chk({tag, " req0_ready"}, {31'b0, req0_ready}, {31'b0, v.e_r0});
    chk({tag, " req1_ready"}, {31'b0, req1_ready}, {31'b0, v.e_r1});
    chk({tag, " resp_valid"}, {31'b0, resp_valid}, {31'b0, v.e_rv});
    chk({tag, " sh_a"}, {26'b0, sh_a}, {26'b0, v.e_sha});
    chk({tag, " sh_b"}, {26'b0, sh_b}, {26'b0, v.e_shb});
    if (v.e_rv) begin
      chk({tag, " resp_id"}, {31'b0, resp_id}, {31'b0, v.e_id});
      chk({tag, " resp_s"}, {26'b0, resp_s}, {26'b0, v.e_s});
    end
  endtask

  task automatic runVec(vec_t v, string tag);
    applyStimulus(v);
    #1;
    checkOutput(v, tag);
    @(negedge clk);
  endtask

  task automatic checkAllZero(string tag);
    chk({tag, " req0_ready"}, {31'b0, req0_ready}, 32'd0);
    chk({tag, " req1_ready"}, {31'b0, req1_ready}, 32'd0);
    chk({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, " resp_id"}, {31'b0, resp_id}, 32'd0);
    chk({tag, " resp_s"}, {26'b0, resp_s}, 32'd0);
    chk({tag, " sh_a"}, {26'b0, sh_a}, 32'd0);
    chk({tag, " sh_b"}, {26'b0, sh_b}, 32'd0);
  endtask

  initial begin
    // Tie: both requesters valid continuously, resp_ready high
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  1,0, 0,0, 0, 0,0));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  0,0, 0,0, 0, 8,3));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  0,0, 1,0, 1, 0,0));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  FIXED,!FIXED, 0,0, 0, 0,0));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  0,0, 0,0, 0, FIXED ? 6'd8 : 6'd63, FIXED ? 6'd3 : 6'd2));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  0,0, 1,!FIXED, FIXED ? 6'd1 : 6'd15, 0,0));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  1,0, 0,0, 0, 0,0));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  0,0, 0,0, 0, 8,3));
    vecs.push_back(mkv(1,8,3, 1,63,2, 1,  0,0, 1,0, 1, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 0,0, 0, 0,0));
    // Single op on requester 0
    vecs.push_back(mkv(1,8,3, 0,0,0,  1,  1,0, 0,0, 0, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 0,0, 0, 8,3));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 1,0, 1, 0,0));
    // Boundaries: zero shift and full-width shift
    vecs.push_back(mkv(0,0,0, 1,63,0, 1,  0,1, 0,0, 0, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 0,0, 0, 63,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 1,1, 63, 0,0));
    vecs.push_back(mkv(1,63,6, 0,0,0, 1,  1,0, 0,0, 0, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 0,0, 0, 63,6));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 1,0, 0, 0,0));
    vecs.push_back(mkv(0,0,0, 0,0,0,  1,  0,0, 0,0, 0, 0,0));

    // Reset state, with both requesters asking so ready masking is exercised
    rst = 1'b1;
    applyStimulus(mkv(1,8,3, 1,63,2, 1, 0,0,0,0,0,0,0));
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      runVec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold the response for 5 cycles while both requesters wait
    runVec(mkv(0,0,0, 1,63,2, 0,  0,1, 0,0, 0, 0,0),  "bp_hs");
    runVec(mkv(0,0,0, 0,0,0,  0,  0,0, 0,0, 0, 63,2), "bp_issue");
    for (int i = 0; i < 5; i++)
      runVec(mkv(1,8,3, 1,63,2, 0,  0,0, 1,1, 15, 0,0), $sformatf("bp_hold%0d", i));
    runVec(mkv(0,0,0, 0,0,0,  1,  0,0, 1,1, 15, 0,0), "bp_release");
    runVec(mkv(0,0,0, 0,0,0,  1,  0,0, 0,0, 0, 0,0),  "bp_done");

    // Reset during ISSUE abandons the op and restores last-grant
    runVec(mkv(1,8,3, 0,0,0, 1,  1,0, 0,0, 0, 0,0), "rm_hs");
    applyStimulus(mkv(1,8,3, 1,63,2, 1, 0,0,0,0,0,0,0));
    #1;
    chk("rm_issue sh_a", {26'b0, sh_a}, 32'd8);
    #2 rst = 1'b1;
    #1;
    checkAllZero("rm_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    runVec(mkv(0,0,0, 0,0,0, 1,  0,0, 0,0, 0, 0,0), "rm_idle0");
    runVec(mkv(0,0,0, 0,0,0, 1,  0,0, 0,0, 0, 0,0), "rm_idle1");
    runVec(mkv(1,8,3, 1,63,2, 1, 1,0, 0,0, 0, 0,0), "rm_tie");
    runVec(mkv(0,0,0, 0,0,0, 1,  0,0, 0,0, 0, 8,3), "rm_issue2");
    runVec(mkv(0,0,0, 0,0,0, 1,  0,0, 1,0, 1, 0,0), "rm_resp");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
